// File: rtl/rtc_bcd_counter_if.sv
// Bus bundle for the BCD real-time clock: tick/load requests in, time and event pulses out.
interface rtc_bcd_counter_if;
    logic        tick;
    logic        en;
    logic        load;
    logic [23:0] load_time;
    logic [7:0]  hour_bcd;
    logic [7:0]  min_bcd;
    logic [7:0]  sec_bcd;
    logic        sec_pulse;
    logic        day_wrap;
    logic        load_err;

    // Driver side: issues ticks and load requests, observes the time.
    modport master (
        output tick, en, load, load_time,
        input  hour_bcd, min_bcd, sec_bcd, sec_pulse, day_wrap, load_err
    );

    // Counter side.
    modport slave (
        input  tick, en, load, load_time,
        output hour_bcd, min_bcd, sec_bcd, sec_pulse, day_wrap, load_err
    );
endinterface

// File: rtl/rtc_bcd_counter.sv
// 24-hour hh:mm:ss time-of-day counter in packed BCD, advanced by a tick prescaler,
// with validated synchronous load and registered second/day-wrap/load-error pulses.
module rtc_bcd_counter #(
    parameter int unsigned TICKS_PER_SEC = 2,
    parameter logic [23:0] RESET_TIME    = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    rtc_bcd_counter_if.slave  bus
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    h_t_q, h_u_q, m_t_q, m_u_q, s_t_q, s_u_q;
    logic [3:0]    h_t_d, h_u_d, m_t_d, m_u_d, s_t_d, s_u_d;
    logic          sec_pulse_q, sec_pulse_d;
    logic          day_wrap_q, day_wrap_d;
    logic          load_err_q, load_err_d;

    function automatic logic time_valid(input logic [23:0] t);
        time_valid = (t[3:0]   <= 4'd9) && (t[7:4]   <= 4'd5) &&
                     (t[11:8]  <= 4'd9) && (t[15:12] <= 4'd5) &&
                     (t[19:16] <= 4'd9) && (t[23:20] <= 4'd2) &&
                     !((t[23:20] == 4'd2) && (t[19:16] > 4'd3));
    endfunction

    // Next-state: load beats tick (tick discarded even if the load is rejected);
    // a qualified tick either bumps the prescaler or advances one second with BCD carries.
    always_comb begin
        presc_d     = presc_q;
        h_t_d       = h_t_q;
        h_u_d       = h_u_q;
        m_t_d       = m_t_q;
        m_u_d       = m_u_q;
        s_t_d       = s_t_q;
        s_u_d       = s_u_q;
        sec_pulse_d = 1'b0;
        day_wrap_d  = 1'b0;
        load_err_d  = 1'b0;

        if (bus.load) begin
            if (time_valid(bus.load_time)) begin
                {h_t_d, h_u_d, m_t_d, m_u_d, s_t_d, s_u_d} = bus.load_time;
                presc_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.tick && bus.en) begin
            if (presc_q == PRESC_MAX) begin
                presc_d     = '0;
                sec_pulse_d = 1'b1;
                if (s_u_q != 4'd9) begin
                    s_u_d = s_u_q + 4'd1;
                end else begin
                    s_u_d = '0;
                    if (s_t_q != 4'd5) begin
                        s_t_d = s_t_q + 4'd1;
                    end else begin
                        s_t_d = '0;
                        if (m_u_q != 4'd9) begin
                            m_u_d = m_u_q + 4'd1;
                        end else begin
                            m_u_d = '0;
                            if (m_t_q != 4'd5) begin
                                m_t_d = m_t_q + 4'd1;
                            end else begin
                                m_t_d = '0;
                                if ((h_t_q == 4'd2) && (h_u_q == 4'd3)) begin
                                    h_t_d      = '0;
                                    h_u_d      = '0;
                                    day_wrap_d = 1'b1;
                                end else if (h_u_q == 4'd9) begin
                                    h_u_d = '0;
                                    h_t_d = h_t_q + 4'd1;
                                end else begin
                                    h_u_d = h_u_q + 4'd1;
                                end
                            end
                        end
                    end
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // State and pulse registers; reset restores RESET_TIME and drops any partial prescale.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            h_t_q       <= RESET_TIME[23:20];
            h_u_q       <= RESET_TIME[19:16];
            m_t_q       <= RESET_TIME[15:12];
            m_u_q       <= RESET_TIME[11:8];
            s_t_q       <= RESET_TIME[7:4];
            s_u_q       <= RESET_TIME[3:0];
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            h_t_q       <= h_t_d;
            h_u_q       <= h_u_d;
            m_t_q       <= m_t_d;
            m_u_q       <= m_u_d;
            s_t_q       <= s_t_d;
            s_u_q       <= s_u_d;
            sec_pulse_q <= sec_pulse_d;
            day_wrap_q  <= day_wrap_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.hour_bcd  = {h_t_q, h_u_q};
    assign bus.min_bcd   = {m_t_q, m_u_q};
    assign bus.sec_bcd   = {s_t_q, s_u_q};
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.day_wrap  = day_wrap_q;
    assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// Self-checking bench for rtc_bcd_counter: directed plan followed by random traffic,
// compared each cycle against a seconds-of-day reference model.
module tb_rtc_bcd_counter;

    localparam int TPS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total_n = 0;
    int   pass_n  = 0;
    int   fail_n  = 0;

    // Reference model: time as seconds since midnight, prescale as a plain count.
    int m_secs  = 0;
    int m_presc = 0;
    bit m_sp = 0, m_dw = 0, m_le = 0;
    int sp_seen = 0;

    rtc_bcd_counter_if bus ();

    rtc_bcd_counter #(
        .TICKS_PER_SEC (TPS),
        .RESET_TIME    (24'h000000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return 24'((h / 10) << 20 | (h % 10) << 16 | (m / 10) << 12 |
                   (m % 10) << 8 | (x / 10) << 4 | (x % 10));
    endfunction

    function automatic bit decode(input logic [23:0] t, output int s);
        int d[6];
        for (int i = 0; i < 6; i++) d[i] = int'((t >> (4 * (5 - i))) & 24'hF);
        s = 0;
        for (int i = 0; i < 6; i++) if (d[i] > 9) return 0;
        if (d[0] * 10 + d[1] > 23) return 0;
        if (d[2] * 10 + d[3] > 59) return 0;
        if (d[4] * 10 + d[5] > 59) return 0;
        s = (d[0] * 10 + d[1]) * 3600 + (d[2] * 10 + d[3]) * 60 + d[4] * 10 + d[5];
        return 1;
    endfunction

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total_n++;
        assert (got === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the same rules, compare all outputs.
    task automatic step(input bit r, input bit t, input bit e, input bit l, input logic [23:0] lt);
        int s;
        rst = r; bus.tick = t; bus.en = e; bus.load = l; bus.load_time = lt;
        @(posedge clk);
        #1;
        m_sp = 0; m_dw = 0; m_le = 0;
        if (r) begin
            m_secs = 0; m_presc = 0;
        end else if (l) begin
            if (decode(lt, s)) begin
                m_secs = s; m_presc = 0;
            end else begin
                m_le = 1;
            end
        end else if (t && e) begin
            if (m_presc == TPS - 1) begin
                m_presc = 0;
                m_secs  = (m_secs + 1) % 86400;
                m_sp    = 1;
                m_dw    = (m_secs == 0);
            end else begin
                m_presc++;
            end
        end
        if (bus.sec_pulse === 1'b1) sp_seen++;
        check("time", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}, to_bcd(m_secs));
        check("sec_pulse", 24'(bus.sec_pulse), 24'(m_sp));
        check("day_wrap", 24'(bus.day_wrap), 24'(m_dw));
        check("load_err", 24'(bus.load_err), 24'(m_le));
    endtask

    task automatic idle(input int n, input bit e);
        for (int i = 0; i < n; i++) step(0, 0, e, 0, 24'h0);
    endtask

    initial begin
        int sp_base;
        bus.tick = 0; bus.en = 0; bus.load = 0; bus.load_time = '0;

        // 1: reset overrides tick and load, then hold with no ticks
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 24'h123456);
        idle(3, 1);
        check("hold_time", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}, 24'h000000);

        // 2: basic count, two ticks per second, five cycles apart
        sp_base = sp_seen;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0, 24'h0);
            idle(4, 1);
        end
        check("pulse_count", 24'(sp_seen - sp_base), 24'd2);
        check("sec_after_4", 24'(bus.sec_bcd), 24'h02);

        // 3: rollovers, including day wrap and hour carry
        step(0, 0, 1, 1, 24'h235958);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 24'h0);
        check("wrap_time", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}, 24'h000000);
        step(0, 0, 1, 1, 24'h095959);
        for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 24'h0);
        check("hour_carry", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}, 24'h100000);

        // 4: load validation
        step(0, 0, 1, 1, 24'h240000); idle(1, 1);
        step(0, 0, 1, 1, 24'h126000); idle(1, 1);
        step(0, 0, 1, 1, 24'h12345A); idle(1, 1);
        step(0, 0, 1, 1, 24'h195930);
        check("valid_load", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}, 24'h195930);

        // 5: load beats a tick that would complete a second, and clears prescale
        step(0, 1, 1, 0, 24'h0);
        step(0, 1, 1, 1, 24'h010203);
        step(0, 1, 1, 0, 24'h0);
        step(0, 1, 1, 0, 24'h0);
        check("prio_time", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}, 24'h010204);

        // 6: enable gating, then reset mid-prescale
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 24'h0);
        step(0, 1, 1, 0, 24'h0);
        step(1, 0, 1, 0, 24'h0);
        step(0, 1, 1, 0, 24'h0);
        check("rst_presc", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}, 24'h000000);

        // Random traffic, with loads biased toward the end of day to reach the wrap
        for (int i = 0; i < 3000; i++) begin
            bit r, t, e, l;
            logic [23:0] lt;
            r = ($urandom_range(0, 199) == 0);
            t = ($urandom_range(0, 1) == 1);
            e = ($urandom_range(0, 4) != 0);
            l = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 2))
                0:       lt = to_bcd(int'($urandom_range(0, 86399)));
                1:       lt = to_bcd(int'($urandom_range(86380, 86399)));
                default: lt = 24'($urandom());
            endcase
            step(r, t, e, l, lt);
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
